// File: rtl/dot16_sequencer.sv
// 16-term multiply-accumulate sequencer: drives the operand-mux select and accumulates one dot product per start.
// Define DOT16_SIGNED_MAC_EN for two's-complement operands; the default build is unsigned.
module dot16_sequencer #(
  parameter int N_TERMS = 16,
  parameter int ACC_W   = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       sel,
  input  logic [15:0]      a_in,
  input  logic [15:0]      b_in,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] LAST_SEL = 4'(N_TERMS - 1);

  state_t             state_r;
  state_t             state_s;
  logic [3:0]         cnt_r;
  logic [31:0]        prod_r;
  logic               prod_v_r;
  logic [ACC_W-1:0]   acc_r;
  logic [ACC_W-1:0]   result_r;
  logic               done_r;

  // 16x16 product, signedness chosen by build configuration
  function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b);
`ifdef DOT16_SIGNED_MAC_EN
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = 32'(signed'(a));
    sb = 32'(signed'(b));
    mul16 = 32'(sa * sb);
`else
    mul16 = {16'h0000, a} * {16'h0000, b};
`endif
  endfunction

  // Widen a product to accumulator width (sign- or zero-extend)
  function automatic logic [ACC_W-1:0] ext(input logic [31:0] p);
`ifdef DOT16_SIGNED_MAC_EN
    ext = {{(ACC_W-32){p[31]}}, p};
`else
    ext = {{(ACC_W-32){1'b0}}, p};
`endif
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_SEL) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: product pipeline register, accumulator, result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= 4'd0;
      prod_r   <= 32'd0;
      prod_v_r <= 1'b0;
      acc_r    <= '0;
      result_r <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= (state_r == DRAIN);
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r    <= 4'd0;
            acc_r    <= '0;
            prod_v_r <= 1'b0;
          end
        end
        RUN: begin
          prod_r   <= mul16(a_in, b_in);
          prod_v_r <= 1'b1;
          if (prod_v_r) begin
            acc_r <= acc_r + ext(prod_r);
          end
          // wraps 15 -> 0 on the DRAIN transition
          cnt_r <= cnt_r + 4'd1;
        end
        DRAIN: begin
          result_r <= acc_r + ext(prod_r);
          prod_v_r <= 1'b0;
        end
        default: begin
          cnt_r    <= 4'd0;
          prod_v_r <= 1'b0;
        end
      endcase
    end
  end

  assign sel    = cnt_r;
  assign busy   = (state_r != IDLE);
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_dot16_sequencer.sv
// Bench for dot16_sequencer: models the two operand muxes and checks results, latency and handshake.
module tb_dot16_sequencer;

  localparam int ACC_W = 36;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [3:0]       sel;
  logic [15:0]      a_in;
  logic [15:0]      b_in;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] result;
  logic [2:0]       mode;

  int n_checks = 0;
  int n_fails  = 0;

  dot16_sequencer #(.N_TERMS(16), .ACC_W(ACC_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sel    (sel),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand mux model: combinational from sel
  always_comb begin
    a_in = 16'h0000;
    b_in = 16'h0000;
    case (mode)
      3'd0: begin a_in = 16'h0001;         b_in = 16'h0001;         end
      3'd1: begin a_in = {12'h000, sel};   b_in = {12'h000, sel};   end
      3'd2: begin a_in = 16'hFFFF;         b_in = 16'hFFFF;         end
      3'd3: begin a_in = 16'hFFFF;         b_in = 16'h0001;         end
      3'd4: begin a_in = 16'h8000;         b_in = 16'h7FFF;         end
      3'd5: begin a_in = {12'h000, sel};   b_in = 16'h0001;         end
      3'd6: begin a_in = 16'h1234;         b_in = 16'h0000;         end
      3'd7: begin a_in = {sel, sel, sel, sel}; b_in = 16'h0003;     end
      default: begin a_in = 16'h0000;      b_in = 16'h0000;         end
    endcase
  end

  typedef struct {
    logic [2:0]       mode;
    logic [ACC_W-1:0] exp_result;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One full transaction: start pulse, 16 terms, drain, done.
  task automatic run_vec(input logic [2:0] m, input logic [ACC_W-1:0] exp);
    logic [ACC_W-1:0] prev;
    logic busy_ok, sel_ok, done_ok, hold_ok;
    busy_ok = 1'b1; sel_ok = 1'b1; done_ok = 1'b1; hold_ok = 1'b1;
    @(negedge clk);
    mode  = m;
    prev  = result;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done !== 1'b0) done_ok = 1'b0;
      if (result !== prev) hold_ok = 1'b0;
      if (n <= 16 && sel !== 4'(n - 1)) sel_ok = 1'b0;
      @(negedge clk);
    end
    chk("busy_window", {63'd0, busy_ok}, 64'd1);
    chk("sel_steps",   {63'd0, sel_ok},  64'd1);
    chk("done_early",  {63'd0, done_ok}, 64'd1);
    chk("result_hold", {63'd0, hold_ok}, 64'd1);
    chk("done_at_17",  {63'd0, done},    64'd1);
    chk("busy_after",  {63'd0, busy},    64'd0);
    chk("result",      64'(result),      64'(exp));
    @(negedge clk);
    chk("done_pulse",  {63'd0, done},    64'd0);
    chk("result_kept", 64'(result),      64'(exp));
  endtask

  initial begin
    int done_cnt;
    int done_pos [3];
    logic found;

    vecs[0] = '{3'd0, 36'd16};
    vecs[1] = '{3'd1, 36'd1240};
    vecs[5] = '{3'd5, 36'd120};
    vecs[6] = '{3'd6, 36'd0};
`ifdef DOT16_SIGNED_MAC_EN
    vecs[2] = '{3'd2, 36'd16};
    vecs[3] = '{3'd3, 36'hFFFFFFFF0};
    vecs[4] = '{3'd4, 36'hC00080000};
    vecs[7] = '{3'd7, 36'hFFFFFFFE8};
`else
    vecs[2] = '{3'd2, 36'hFFFE00010};
    vecs[3] = '{3'd3, 36'd1048560};
    vecs[4] = '{3'd4, 36'h3FFF80000};
    vecs[7] = '{3'd7, 36'd1572840};
`endif

    mode  = 3'd0;
    start = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_sel",    64'(sel),    64'd0);
    chk("rst_busy",   64'(busy),   64'd0);
    chk("rst_done",   64'(done),   64'd0);
    chk("rst_result", 64'(result), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i].mode, vecs[i].exp_result);
    end

    // Reset mid-run at sel==7, then a clean rerun
    @(negedge clk);
    mode  = 3'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (sel == 4'd7) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach_sel7", {63'd0, found}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_sel",    64'(sel),    64'd0);
    chk("abort_busy",   64'(busy),   64'd0);
    chk("abort_done",   64'(done),   64'd0);
    chk("abort_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(3'd1, 36'd1240);

    // start held high: a result every 18 cycles
    @(negedge clk);
    mode     = 3'd0;
    start    = 1'b1;
    done_cnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin
        if (done_cnt < 3) done_pos[done_cnt] = n;
        done_cnt++;
        chk("held_result", 64'(result), 64'd16);
      end
    end
    start = 1'b0;
    chk("held_count", 64'(done_cnt), 64'd3);
    if (done_cnt == 3) begin
      chk("held_first",  64'(done_pos[0]), 64'd18);
      chk("held_period", 64'(done_pos[1] - done_pos[0]), 64'd18);
      chk("held_period", 64'(done_pos[2] - done_pos[1]), 64'd18);
    end
    repeat (25) @(negedge clk);
    chk("held_idle", 64'(busy), 64'd0);

    // start pulse during RUN is ignored
    mode  = 3'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) begin
        done_cnt++;
        chk("ignored_result", 64'(result), 64'd1240);
      end
      @(negedge clk);
    end
    chk("ignored_count", 64'(done_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule
